// File: rtl/round_ctrl_pkg.sv
// Shared definitions for the number-guess round sequencer: state codes,
// tone codes, start-pulse indices and the per-level guess width/mask.
package round_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_GREET = 4'd1,
        ST_ARM   = 4'd2,
        ST_COUNT = 4'd3,
        ST_GUESS = 4'd4,
        ST_JUDGE = 4'd5,
        ST_BEEP  = 4'd6,
        ST_WIN   = 4'd7,
        ST_LOSE  = 4'd8
    } state_t;

    localparam logic BEEP_OK  = 1'b0;
    localparam logic BEEP_ERR = 1'b1;

    // Bit positions of the start strobes inside the pulse generator.
    localparam int PG_RAND = 0;
    localparam int PG_CST  = 1;
    localparam int PG_BST  = 2;
    localparam int PG_N    = 3;

    function automatic int unsigned lvl_width(input int unsigned w0, input logic [1:0] lvl);
        return w0 + 32'(lvl);
    endfunction

    function automatic logic [6:0] lvl_mask(input int unsigned w0, input logic [1:0] lvl);
        logic [6:0] ones;
        ones = '1;
        return ones >> (7 - lvl_width(w0, lvl));
    endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Pin bundle between the round sequencer and the board top / peripherals.
interface round_ctrl_if;
    logic        en;
    logic        go;
    logic        confirm;
    logic [6:0]  sw;
    logic [6:0]  rand_num;
    logic        cnt_over;
    logic        beep_over;
    logic        rand_st;
    logic        cst;
    logic [2:0]  dz_num;
    logic        bst;
    logic        beep_kind;
    logic [1:0]  disp_num;
    logic [15:0] led;
    logic [1:0]  level;
    logic [3:0]  tries;
    logic        win;
    logic        lose;

    modport slave (
        input  en, go, confirm, sw, rand_num, cnt_over, beep_over,
        output rand_st, cst, dz_num, bst, beep_kind, disp_num, led,
               level, tries, win, lose
    );

    modport master (
        output en, go, confirm, sw, rand_num, cnt_over, beep_over,
        input  rand_st, cst, dz_num, bst, beep_kind, disp_num, led,
               level, tries, win, lose
    );
endinterface

// File: rtl/round_ctrl_pulse_gen.sv
// Registers the FSM's start requests so each start output is a clean
// one-cycle strobe in the cycle after the request.
module round_ctrl_pulse_gen
    import round_ctrl_pkg::*;
#(
    parameter int N = PG_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] pulse
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse <= '0;
        else     pulse <= req;
    end

endmodule

// File: rtl/round_ctrl.sv
// Game sequencer: starts the random/countdown/buzzer blocks, judges the
// switch guess and tracks level, tries and the win/lose outcome.
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned CNT_SECS  = 3,
    parameter int unsigned W0        = 5
) (
    input logic         clk,
    input logic         rst,
    round_ctrl_if.slave bus
);

    state_t          state, state_n;
    logic [1:0]      level;
    logic [3:0]      tries;
    logic [6:0]      target;
    logic [6:0]      guess;
    logic            hit;
    logic            kind_q;
    logic [6:0]      cur_mask;
    logic            judge_hit;
    logic [PG_N-1:0] req, pulse;

    logic clr_all, clr_game, lat_tgt, cap_sw, do_judge, lvl_inc;

    assign cur_mask  = lvl_mask(W0, level);
    assign judge_hit = ((guess & cur_mask) == target);

    always_comb begin
        state_n  = state;
        req      = '0;
        clr_all  = 1'b0;
        clr_game = 1'b0;
        lat_tgt  = 1'b0;
        cap_sw   = 1'b0;
        do_judge = 1'b0;
        lvl_inc  = 1'b0;
        if (!bus.en) begin
            state_n = ST_IDLE;
            clr_all = 1'b1;
        end else if (bus.go && state != ST_IDLE) begin
            state_n       = ST_ARM;
            clr_game      = 1'b1;
            req[PG_RAND]  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_GREET;
                // ARM spends one cycle with rand_st high, then latches the
                // target in the cycle where cst is high.
                ST_ARM: begin
                    if (pulse[PG_RAND]) begin
                        req[PG_CST] = 1'b1;
                    end else begin
                        lat_tgt = 1'b1;
                        state_n = ST_COUNT;
                    end
                end
                ST_COUNT: if (bus.cnt_over) state_n = ST_GUESS;
                ST_GUESS: begin
                    if (bus.confirm) begin
                        cap_sw  = 1'b1;
                        state_n = ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    do_judge    = 1'b1;
                    req[PG_BST] = 1'b1;
                    state_n     = ST_BEEP;
                end
                ST_BEEP: begin
                    if (bus.beep_over) begin
                        if (hit) begin
                            if (level == 2'd2) begin
                                state_n = ST_WIN;
                            end else begin
                                lvl_inc      = 1'b1;
                                req[PG_RAND] = 1'b1;
                                state_n      = ST_ARM;
                            end
                        end else if (tries == 4'(MAX_TRIES)) begin
                            state_n = ST_LOSE;
                        end else begin
                            req[PG_CST] = 1'b1;
                            state_n     = ST_COUNT;
                        end
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            level  <= '0;
            tries  <= '0;
            target <= '0;
            guess  <= '0;
            hit    <= 1'b0;
            kind_q <= BEEP_OK;
        end else begin
            state <= state_n;
            if (clr_all || clr_game) begin
                level <= '0;
                tries <= '0;
            end else begin
                if (lvl_inc) level <= level + 2'd1;
                if (do_judge && !judge_hit && tries != 4'(MAX_TRIES))
                    tries <= tries + 4'd1;
            end
            if (clr_all)      target <= '0;
            else if (lat_tgt) target <= bus.rand_num & cur_mask;
            if (cap_sw) guess <= bus.sw;
            if (clr_all) begin
                hit    <= 1'b0;
                kind_q <= BEEP_OK;
            end else if (do_judge) begin
                hit    <= judge_hit;
                kind_q <= judge_hit ? BEEP_OK : BEEP_ERR;
            end
        end
    end

    round_ctrl_pulse_gen #(.N(PG_N)) u_pulse (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pulse (pulse)
    );

    always_comb begin
        case (state)
            ST_IDLE, ST_GREET: bus.disp_num = 2'd0;
            ST_WIN, ST_LOSE:   bus.disp_num = 2'd3;
            default:           bus.disp_num = level + 2'd1;
        endcase
    end

    assign bus.rand_st   = pulse[PG_RAND];
    assign bus.cst       = pulse[PG_CST];
    assign bus.bst       = pulse[PG_BST];
    assign bus.beep_kind = kind_q;
    assign bus.dz_num    = 3'(CNT_SECS);
    assign bus.led       = {9'd0, target};
    assign bus.level     = level;
    assign bus.tries     = tries;
    assign bus.win       = (state == ST_WIN);
    assign bus.lose      = (state == ST_LOSE);

endmodule

// File: tb/tb_round_ctrl.sv
// Randomized game-level bench for round_ctrl: a plain-integer game model
// predicts each buzzer strobe, which a negedge monitor checks from a queue.
module tb_round_ctrl;
    localparam int MAX_T = 8;
    localparam int W0    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    round_ctrl_if bus();

    round_ctrl #(.MAX_TRIES(MAX_T), .CNT_SECS(3), .W0(W0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int kind; int due; } bst_exp_t;
    bst_exp_t bq[$];

    int   n_cst = 0, n_rand = 0;
    logic prev_cst = 1'b0, prev_rand = 1'b0;

    // game model
    int m_level = 0, m_tries = 0, m_target = 0;
    bit m_win = 0, m_lose = 0, m_at_arm = 0;

    function automatic int mask_of(input int lvl);
        return (1 << (W0 + lvl)) - 1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    always @(negedge clk) begin : mon
        bst_exp_t e;
        if (bus.bst) begin
            if (bq.size() == 0) fail("bst_unexpected", "bst high with nothing pending");
            else begin
                e = bq.pop_front();
                check("beep_kind", int'(bus.beep_kind), e.kind);
                check("bst_latency", cyc, e.due);
            end
        end else if (bq.size() != 0 && cyc > bq[0].due) begin
            fail("bst_missing", "expected bst never appeared");
            e = bq.pop_front();
        end
        if (bus.cst) begin
            n_cst++;
            check("cst_width", int'(prev_cst), 0);
        end
        if (bus.rand_st) begin
            n_rand++;
            check("rand_st_width", int'(prev_rand), 0);
        end
        prev_cst  = bus.cst;
        prev_rand = bus.rand_st;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input string name, input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = bus.rand_st;
                1:       ok = bus.cst;
                2:       ok = bus.bst;
                default: ok = 1'b0;
            endcase
        end
        if (!ok) fail(name, "timed out waiting for strobe");
    endtask

    task automatic do_confirm(input logic [6:0] g, input bit judged);
        step();
        bus.sw      = g;
        bus.confirm = 1'b1;
        if (judged) begin
            bst_exp_t e;
            e.kind = (((int'(g) & mask_of(m_level)) == m_target) ? 0 : 1);
            e.due  = cyc + 2;
            bq.push_back(e);
        end
        step();
        bus.confirm = 1'b0;
    endtask

    task automatic new_game();
        step();
        bus.go = 1'b1;
        step();
        bus.go   = 1'b0;
        m_level  = 0;
        m_tries  = 0;
        m_win    = 0;
        m_lose   = 0;
        m_at_arm = 1;
    endtask

    // Runs through ARM (new target) or a bare recount (same target).
    task automatic arm_phase(input int rnd, output bit ok);
        bus.rand_num = 7'(rnd);
        ok = 1'b1;
        if (m_at_arm) wait_for("wait_rand_st", 0, ok);
        if (ok) wait_for("wait_cst", 1, ok);
        if (!ok) return;
        if (m_at_arm) m_target = rnd & mask_of(m_level);
        m_at_arm = 0;
        step();
        bus.rand_num = 7'($urandom);
    endtask

    task automatic play_round(input int rnd, input int guess_in, input bit want_hit,
                              input int cnt_dly, input bit noise, input bit go_in_beep);
        bit ok, hit;
        int msk, g;
        msk = mask_of(m_level);
        arm_phase(rnd, ok);
        if (!ok) return;
        if (noise) begin
            do_confirm(7'($urandom), 1'b0);
            bus.beep_over = 1'b1;
            step();
            bus.beep_over = 1'b0;
        end
        repeat (cnt_dly) step();
        bus.cnt_over  = 1'b1;
        bus.beep_over = noise;
        step();
        bus.cnt_over  = 1'b0;
        bus.beep_over = 1'b0;
        check("led", int'(bus.led), m_target);
        if (noise) begin
            bus.cnt_over = 1'b1;
            step();
            bus.cnt_over = 1'b0;
        end
        if (guess_in >= 0)  g = guess_in;
        else if (want_hit)  g = m_target | (int'($urandom_range(0, 127)) & ~msk);
        else g = (m_target ^ (1 << $urandom_range(0, W0 + m_level - 1)))
                 | (int'($urandom_range(0, 127)) & ~msk);
        repeat ($urandom_range(0, 3)) step();
        do_confirm(7'(g), 1'b1);
        wait_for("wait_bst", 2, ok);
        if (!ok) return;
        hit = ((g & msk) == m_target);
        if (!hit && m_tries < MAX_T) m_tries++;
        step();
        if (go_in_beep) begin
            bus.go = 1'b1;
            step();
            bus.go   = 1'b0;
            m_level  = 0;
            m_tries  = 0;
            m_at_arm = 1;
            check("go_rand_st", int'(bus.rand_st), 1);
            check("go_level", int'(bus.level), m_level);
            check("go_tries", int'(bus.tries), m_tries);
            return;
        end
        repeat ($urandom_range(0, 3)) step();
        bus.beep_over = 1'b1;
        bus.cnt_over  = noise;
        step();
        bus.beep_over = 1'b0;
        bus.cnt_over  = 1'b0;
        if (hit) begin
            if (m_level == 2) m_win = 1;
            else begin
                m_level++;
                m_at_arm = 1;
            end
        end else if (m_tries == MAX_T) m_lose = 1;
        check("level", int'(bus.level), m_level);
        check("tries", int'(bus.tries), m_tries);
        check("win", int'(bus.win), int'(m_win));
        check("lose", int'(bus.lose), int'(m_lose));
        check("disp_num", int'(bus.disp_num), (m_win || m_lose) ? 3 : m_level + 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_level"}, int'(bus.level), 0);
        check({tag, "_tries"}, int'(bus.tries), 0);
        check({tag, "_led"}, int'(bus.led), 0);
        check({tag, "_disp"}, int'(bus.disp_num), 0);
        check({tag, "_win"}, int'(bus.win), 0);
        check({tag, "_lose"}, int'(bus.lose), 0);
        check({tag, "_kind"}, int'(bus.beep_kind), 0);
        check({tag, "_pulses"}, int'({bus.rand_st, bus.cst, bus.bst}), 0);
        check({tag, "_dz_num"}, int'(bus.dz_num), 3);
    endtask

    initial begin
        bit ok;
        int cst0, rnd0;
        bus.en = 1'b0; bus.go = 1'b0; bus.confirm = 1'b0; bus.sw = '0;
        bus.rand_num = '0; bus.cnt_over = 1'b0; bus.beep_over = 1'b0;
        step();
        check_cleared("reset");
        step();
        rst = 1'b0;
        step();
        bus.en = 1'b1;
        step();

        // directed first level, then two hits with full-width random
        new_game();
        play_round('h35, 'h15, 1'b1, 10, 1'b0, 1'b0);
        check("t1_led", int'(bus.led), 'h15);
        play_round('h7f, -1, 1'b1, 4, 1'b1, 1'b0);
        play_round('h7f, -1, 1'b1, 2, 1'b0, 1'b0);
        check("t3_led", int'(bus.led), m_target);
        do_confirm(7'h00, 1'b0);
        repeat (4) step();
        check("t3_win_hold", int'(bus.win), int'(m_win));
        check("t3_disp", int'(bus.disp_num), 3);

        // restart from WIN, go during BEEP at level 2
        new_game();
        play_round(int'($urandom_range(0, 127)), -1, 1'b1, 3, 1'b0, 1'b0);
        play_round(int'($urandom_range(0, 127)), -1, 1'b1, 3, 1'b0, 1'b0);
        play_round(int'($urandom_range(0, 127)), -1, 1'b0, 3, 1'b0, 1'b1);

        // eight misses at level 0 -> LOSE, then nothing restarts
        for (int i = 0; i < MAX_T; i++)
            play_round(int'($urandom_range(0, 127)), -1, 1'b0,
                       int'($urandom_range(1, 6)), bit'(i % 2), 1'b0);
        cst0 = n_cst;
        rnd0 = n_rand;
        repeat (3) begin
            step();
            bus.cnt_over = 1'b1; bus.confirm = 1'b1; bus.beep_over = 1'b1;
            step();
            bus.cnt_over = 1'b0; bus.confirm = 1'b0; bus.beep_over = 1'b0;
        end
        repeat (8) step();
        check("t2_no_cst", n_cst, cst0);
        check("t2_no_rand", n_rand, rnd0);
        check("t2_lose", int'(bus.lose), int'(m_lose));

        // random games
        for (int gm = 0; gm < 4; gm++) begin
            new_game();
            for (int r = 0; r < 24 && !m_win && !m_lose; r++)
                play_round(int'($urandom_range(0, 127)), -1, ($urandom_range(0, 2) == 0),
                           int'($urandom_range(1, 12)), bit'($urandom_range(0, 1)), 1'b0);
        end

        // en dropped in COUNT together with cnt_over
        new_game();
        play_round(int'($urandom_range(0, 127)), -1, 1'b1, 2, 1'b0, 1'b0);
        arm_phase(int'($urandom_range(1, 127)) | 1, ok);
        repeat (3) step();
        bus.en = 1'b0;
        bus.cnt_over = 1'b1;
        step();
        bus.cnt_over = 1'b0;
        check_cleared("t5");
        cst0 = n_cst;
        repeat (8) step();
        check("t5_quiet", n_cst, cst0);
        bus.en = 1'b1;
        step();

        // async reset while waiting in GUESS at level 1
        new_game();
        play_round(int'($urandom_range(0, 127)), -1, 1'b1, 2, 1'b0, 1'b0);
        arm_phase(int'($urandom_range(1, 127)) | 1, ok);
        repeat (2) step();
        bus.cnt_over = 1'b1;
        step();
        bus.cnt_over = 1'b0;
        step();
        check("t7_pre_level", int'(bus.level), m_level);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("t7");
        step();
        rst = 1'b0;
        repeat (6) step();
        check("bst_pending", bq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
